timer_round_ctrl: RTL and testbench

//  Sequences the 1 Hz countdown-timer function across a multi-round challenge.

---
 rtl/timer_round_ctrl_if.sv | 26 ++
 rtl/timer_round_ctrl.sv | 119 +++++++++++
 tb/tb_timer_round_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/timer_round_ctrl_if.sv
// Switch/sensor inputs and display/status outputs of the round timer.
// The master side drives the controls and the slave side is the controller.
interface timer_round_ctrl_if #(
    parameter int CNT_W = 4
);
    logic             START;
    logic             SOUNDSENSOR;
    logic             PRESET_LD;
    logic [CNT_W-1:0] PRESET_VAL;
    logic [CNT_W-1:0] TSEG0;
    logic             LED;
    logic [2:0]       ROUND;
    logic             BUSY;
    logic             DONE;
    logic [7:0]       BRK_CNT;

    modport master (
        output START, SOUNDSENSOR, PRESET_LD, PRESET_VAL,
        input  TSEG0, LED, ROUND, BUSY, DONE, BRK_CNT
    );

    modport slave (
        input  START, SOUNDSENSOR, PRESET_LD, PRESET_VAL,
        output TSEG0, LED, ROUND, BUSY, DONE, BRK_CNT
    );
endinterface

// File: rtl/timer_round_ctrl.sv
// Multi-round 1 Hz countdown sequencer: arms, runs while sound is present,
// reloads on sound breaks, holds LED after expiry and counts completed rounds.
module timer_round_ctrl #(
    parameter int CNT_W      = 4,
    parameter int PRESET     = 3,
    parameter int ROUNDS     = 4,
    parameter int HOLD_TICKS = 2
) (
    input  logic                CLK1H,
    input  logic                RST,
    timer_round_ctrl_if.slave   bus
);
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_RUN, S_EXPIRED, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] tseg_q, tseg_d;
    logic [2:0]       round_q, round_d;
    logic [7:0]       brk_q, brk_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             led_q, busy_q, done_q;
    logic [CNT_W-1:0] ld_val;

    // A zero preset would expire without ever counting, so it is forced to 1.
    assign ld_val = (bus.PRESET_VAL == '0) ? CNT_W'(1) : bus.PRESET_VAL;

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        tseg_d  = tseg_q;
        round_d = round_q;
        brk_d   = brk_q;
        hold_d  = hold_q;
        if (state_q != S_IDLE && !bus.START) begin
            state_d = S_IDLE;
            tseg_d  = pre_q;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.PRESET_LD) pre_d = ld_val;
                    tseg_d = pre_d;
                    if (bus.START) begin
                        state_d = S_ARMED;
                        round_d = '0;
                        brk_d   = '0;
                    end
                end
                // The arming tick already counts, so ARMED and RUN share the decrement.
                S_ARMED, S_RUN: begin
                    if (bus.SOUNDSENSOR) begin
                        if (tseg_q == CNT_W'(1)) begin
                            tseg_d  = '0;
                            state_d = S_EXPIRED;
                            hold_d  = HW'(HOLD_TICKS - 1);
                        end else begin
                            tseg_d  = tseg_q - CNT_W'(1);
                            state_d = S_RUN;
                        end
                    end else if (state_q == S_RUN) begin
                        tseg_d  = pre_q;
                        state_d = S_ARMED;
                        if (brk_q != 8'hFF) brk_d = brk_q + 8'd1;
                    end
                end
                S_EXPIRED: begin
                    tseg_d = '0;
                    if (hold_q == '0) begin
                        round_d = round_q + 3'd1;
                        if (round_q + 3'd1 == 3'(ROUNDS)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_ARMED;
                            tseg_d  = pre_q;
                        end
                    end else begin
                        hold_d = hold_q - HW'(1);
                    end
                end
                S_DONE:  tseg_d = '0;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK1H) begin
        if (RST) begin
            state_q <= S_IDLE;
            pre_q   <= CNT_W'(PRESET);
            tseg_q  <= CNT_W'(PRESET);
            round_q <= '0;
            brk_q   <= '0;
            hold_q  <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            tseg_q  <= tseg_d;
            round_q <= round_d;
            brk_q   <= brk_d;
            hold_q  <= hold_d;
            led_q   <= (state_d == S_EXPIRED) || (state_d == S_DONE);
            busy_q  <= (state_d == S_ARMED) || (state_d == S_RUN) || (state_d == S_EXPIRED);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign bus.TSEG0   = tseg_q;
    assign bus.LED     = led_q;
    assign bus.ROUND   = round_q;
    assign bus.BUSY    = busy_q;
    assign bus.DONE    = done_q;
    assign bus.BRK_CNT = brk_q;
endmodule

// File: tb/tb_timer_round_ctrl.sv
// Self-checking bench for timer_round_ctrl: vector table, directed corner
// sequences and randomized stimulus against a behavioural game model.
module tb_timer_round_ctrl;
    localparam int ROUNDS = 4;
    localparam int HOLD   = 2;

    logic CLK1H;
    logic RST;
    int   checks   = 0;
    int   failures = 0;

    timer_round_ctrl_if #(.CNT_W(4)) bus ();

    timer_round_ctrl #(.CNT_W(4), .PRESET(3), .ROUNDS(ROUNDS), .HOLD_TICKS(HOLD)) dut (
        .CLK1H (CLK1H),
        .RST   (RST),
        .bus   (bus)
    );

    initial begin
        CLK1H = 1'b0;
        forever #5 CLK1H = ~CLK1H;
    end

    // Behavioural model: game phase as a name, timer value as plain integers.
    typedef enum {P_IDLE, P_WAIT, P_COUNT, P_FLASH, P_OVER} phase_t;
    phase_t m_ph;
    int m_pre, m_t, m_round, m_brk, m_flash_left;

    function automatic int m_led();  return (m_ph == P_FLASH || m_ph == P_OVER) ? 1 : 0; endfunction
    function automatic int m_busy(); return (m_ph == P_WAIT || m_ph == P_COUNT || m_ph == P_FLASH) ? 1 : 0; endfunction
    function automatic int m_done(); return (m_ph == P_OVER) ? 1 : 0; endfunction
    function automatic int m_disp(); return (m_ph == P_FLASH || m_ph == P_OVER) ? 0 : m_t; endfunction

    task automatic model_step(input bit rst, input bit start, input bit ss, input bit ld, input int val);
        if (rst) begin
            m_ph = P_IDLE; m_pre = 3; m_t = 3; m_round = 0; m_brk = 0; m_flash_left = 0;
        end else if (m_ph != P_IDLE && !start) begin
            m_ph = P_IDLE; m_t = m_pre;
        end else if (m_ph == P_IDLE) begin
            if (ld) m_pre = (val == 0) ? 1 : val;
            m_t = m_pre;
            if (start) begin m_ph = P_WAIT; m_round = 0; m_brk = 0; end
        end else if (m_ph == P_WAIT || m_ph == P_COUNT) begin
            if (ss) begin
                m_t = m_t - 1;
                m_ph = (m_t == 0) ? P_FLASH : P_COUNT;
                m_flash_left = HOLD;
            end else if (m_ph == P_COUNT) begin
                m_t = m_pre; m_ph = P_WAIT;
                m_brk = (m_brk < 255) ? m_brk + 1 : 255;
            end
        end else if (m_ph == P_FLASH) begin
            m_flash_left = m_flash_left - 1;
            if (m_flash_left == 0) begin
                m_round = m_round + 1;
                if (m_round == ROUNDS) m_ph = P_OVER;
                else begin m_ph = P_WAIT; m_t = m_pre; end
            end
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input bit rst, input bit start, input bit ss, input bit ld, input int val);
        RST = rst; bus.START = start; bus.SOUNDSENSOR = ss; bus.PRESET_LD = ld; bus.PRESET_VAL = 4'(val);
        model_step(rst, start, ss, ld, val);
        @(posedge CLK1H);
        #1;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".TSEG0"},   8'(bus.TSEG0),   8'(m_disp()));
        chk({tag, ".LED"},     8'(bus.LED),     8'(m_led()));
        chk({tag, ".ROUND"},   8'(bus.ROUND),   8'(m_round));
        chk({tag, ".BUSY"},    8'(bus.BUSY),    8'(m_busy()));
        chk({tag, ".DONE"},    8'(bus.DONE),    8'(m_done()));
        chk({tag, ".BRK_CNT"}, bus.BRK_CNT,     8'(m_brk));
    endtask

    typedef struct {
        bit rst, start, ss, ld;
        int val;
        int t, led, rnd, busy, done, brk;
    } vec_t;

    function automatic vec_t mk(bit rst, bit start, bit ss, bit ld, int val,
                                int t, int led, int rnd, int busy, int done, int brk);
        vec_t v;
        v.rst = rst; v.start = start; v.ss = ss; v.ld = ld; v.val = val;
        v.t = t; v.led = led; v.rnd = rnd; v.busy = busy; v.done = done; v.brk = brk;
        return v;
    endfunction

    vec_t tbl[20];

    initial begin
        RST = 1'b1; bus.START = 1'b0; bus.SOUNDSENSOR = 1'b0; bus.PRESET_LD = 1'b0; bus.PRESET_VAL = 4'd0;
        model_step(1, 0, 0, 0, 0);
        repeat (2) @(posedge CLK1H);
        #1;

        //        rst st ss ld val   t led rnd busy done brk
        tbl[0]  = mk(1, 0, 0, 0, 0,  3, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 0,  3, 0, 0, 1, 0, 0);
        tbl[2]  = mk(0, 1, 1, 0, 0,  2, 0, 0, 1, 0, 0);
        tbl[3]  = mk(0, 1, 1, 0, 0,  1, 0, 0, 1, 0, 0);
        tbl[4]  = mk(0, 1, 1, 0, 0,  0, 1, 0, 1, 0, 0);
        tbl[5]  = mk(0, 1, 1, 0, 0,  0, 1, 0, 1, 0, 0);
        tbl[6]  = mk(0, 1, 1, 0, 0,  3, 0, 1, 1, 0, 0);
        tbl[7]  = mk(0, 1, 1, 0, 0,  2, 0, 1, 1, 0, 0);
        tbl[8]  = mk(0, 1, 0, 0, 0,  3, 0, 1, 1, 0, 1);
        tbl[9]  = mk(0, 1, 1, 0, 0,  2, 0, 1, 1, 0, 1);
        tbl[10] = mk(0, 1, 1, 0, 0,  1, 0, 1, 1, 0, 1);
        tbl[11] = mk(0, 1, 0, 0, 0,  3, 0, 1, 1, 0, 2);
        tbl[12] = mk(0, 0, 0, 0, 0,  3, 0, 1, 0, 0, 2);
        tbl[13] = mk(0, 0, 0, 1, 0,  1, 0, 1, 0, 0, 2);
        tbl[14] = mk(0, 1, 1, 0, 0,  1, 0, 0, 1, 0, 0);
        tbl[15] = mk(0, 1, 1, 1, 9,  0, 1, 0, 1, 0, 0);
        tbl[16] = mk(0, 1, 1, 0, 0,  0, 1, 0, 1, 0, 0);
        tbl[17] = mk(0, 1, 1, 0, 0,  1, 0, 1, 1, 0, 0);
        tbl[18] = mk(0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0);
        tbl[19] = mk(0, 0, 0, 1, 3,  3, 0, 1, 0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            step(tbl[i].rst, tbl[i].start, tbl[i].ss, tbl[i].ld, tbl[i].val);
            chk({tag, ".TSEG0"},   8'(bus.TSEG0),   8'(tbl[i].t));
            chk({tag, ".LED"},     8'(bus.LED),     8'(tbl[i].led));
            chk({tag, ".ROUND"},   8'(bus.ROUND),   8'(tbl[i].rnd));
            chk({tag, ".BUSY"},    8'(bus.BUSY),    8'(tbl[i].busy));
            chk({tag, ".DONE"},    8'(bus.DONE),    8'(tbl[i].done));
            chk({tag, ".BRK_CNT"}, bus.BRK_CNT,     8'(tbl[i].brk));
        end

        // Full game with sound held throughout, bounded wait for DONE.
        for (int i = 0; i < 60 && bus.DONE !== 1'b1; i++) begin
            step(0, 1, 1, 0, 0);
            cmp_model("game");
        end
        chk("game.DONE",  8'(bus.DONE),  8'd1);
        chk("game.LED",   8'(bus.LED),   8'd1);
        chk("game.ROUND", 8'(bus.ROUND), 8'd4);
        chk("game.TSEG0", 8'(bus.TSEG0), 8'd0);
        chk("game.BUSY",  8'(bus.BUSY),  8'd0);
        step(0, 1, 1, 0, 0);
        chk("game_hold.DONE", 8'(bus.DONE), 8'd1);
        step(0, 0, 0, 0, 0);
        chk("game_end.TSEG0", 8'(bus.TSEG0), 8'd3);
        chk("game_end.DONE",  8'(bus.DONE),  8'd0);
        chk("game_end.LED",   8'(bus.LED),   8'd0);
        chk("game_end.ROUND", 8'(bus.ROUND), 8'd4);

        // Preset load attempted during RUN is ignored.
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 9);
        chk("ld_in_run.TSEG0", 8'(bus.TSEG0), 8'd1);
        step(0, 0, 0, 0, 0);
        chk("ld_in_run.preset_kept", 8'(bus.TSEG0), 8'd3);

        // Abort at TSEG0=2.
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        chk("abort.pre_t", 8'(bus.TSEG0), 8'd2);
        step(0, 0, 1, 0, 0);
        chk("abort.TSEG0", 8'(bus.TSEG0), 8'd3);
        chk("abort.BUSY",  8'(bus.BUSY),  8'd0);
        chk("abort.LED",   8'(bus.LED),   8'd0);

        // Reset while LED is flashing.
        step(0, 1, 0, 0, 0);
        repeat (3) step(0, 1, 1, 0, 0);
        chk("rst_exp.pre_LED", 8'(bus.LED), 8'd1);
        step(1, 1, 1, 0, 0);
        cmp_model("rst_exp");
        chk("rst_exp.TSEG0", 8'(bus.TSEG0), 8'd3);
        chk("rst_exp.LED",   8'(bus.LED),   8'd0);

        // Break counter saturation.
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            step(0, 1, 1, 0, 0);
            step(0, 1, 0, 0, 0);
        end
        chk("sat.BRK_CNT", bus.BRK_CNT, 8'd255);
        cmp_model("sat");

        // Randomized play against the model.
        for (int i = 0; i < 600; i++) begin
            bit r_rst, r_st, r_ss, r_ld;
            int r_val;
            r_rst = ($urandom_range(0, 99) < 2);
            r_st  = ($urandom_range(0, 99) < 92);
            r_ss  = ($urandom_range(0, 99) < 80);
            r_ld  = ($urandom_range(0, 99) < 12);
            r_val = $urandom_range(0, 15);
            step(r_rst, r_st, r_ss, r_ld, r_val);
            cmp_model($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
